// File: rtl/vga_scan_driver.sv
// vga_scan_driver: free-running VGA raster timing with registered colour, syncs, frame tick and frame counter.
module vga_scan_driver #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [11:0] GREY     = 12'h555,
  parameter logic [11:0] BG       = 12'hFFF
) (
  input  logic        PixelClk,
  input  logic        rst,
  input  logic        inGrey,
  input  logic        inWhite,
  output logic [31:0] vgaX,
  output logic [31:0] vgaY,
  output logic        FrameClk,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic [31:0] frameCount
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic h_wrap, v_wrap, video_on, hs_d, vs_d;
  logic [11:0] rgb_d;
  assign vgaX     = 32'(h_q);
  assign vgaY     = 32'(v_q);
  assign h_wrap   = vgaX == H_TOTAL - 1;
  assign v_wrap   = vgaY == V_TOTAL - 1;
  assign h_d      = h_wrap ? '0 : h_q + HW'(1);
  assign v_d      = h_wrap ? (v_wrap ? '0 : v_q + VW'(1)) : v_q;
  assign video_on = (vgaX < H_ACTIVE) && (vgaY < V_ACTIVE);
  assign rgb_d    = !video_on ? 12'h000 : inWhite ? BG : inGrey ? GREY : BG;
  // Syncs are active-low inside their pulse windows.
  assign hs_d     = !((vgaX >= H_ACTIVE + H_FP) && (vgaX < H_ACTIVE + H_FP + H_SYNC));
  assign vs_d     = !((vgaY >= V_ACTIVE + V_FP) && (vgaY < V_ACTIVE + V_FP + V_SYNC));
  always_ff @(posedge PixelClk) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      rgb        <= 12'h000;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      FrameClk   <= 1'b0;
      frameCount <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      rgb        <= rgb_d;
      hsync      <= hs_d;
      vsync      <= vs_d;
      FrameClk   <= vgaY == V_ACTIVE;
      frameCount <= frameCount + 32'(h_wrap && v_wrap);
    end
  end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: randomized self-checking bench on a shrunken raster against a position-arithmetic model.
module tb_vga_scan_driver;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [11:0] GREY = 12'h555, BG = 12'hFFF;
  logic PixelClk = 1'b0, rst = 1'b1, inGrey = 1'b0, inWhite = 1'b0;
  logic [31:0] vgaX, vgaY, frameCount;
  logic FrameClk, hsync, vsync;
  logic [11:0] rgb;
  int tests = 0, fails = 0;
  int n;
  logic fresh, pg, pw;
  logic [31:0] base, e_cnt;
  int e_x, e_y;
  logic [11:0] e_rgb;
  logic e_hs, e_vs, e_fc;

  vga_scan_driver #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                    .GREY(GREY), .BG(BG)) dut (
    .PixelClk(PixelClk), .rst(rst), .inGrey(inGrey), .inWhite(inWhite),
    .vgaX(vgaX), .vgaY(vgaY), .FrameClk(FrameClk), .hsync(hsync),
    .vsync(vsync), .rgb(rgb), .frameCount(frameCount));

  always #5 PixelClk = ~PixelClk;

  function automatic logic [11:0] ref_rgb(int x, int y, logic g, logic w);
    if (x >= HA || y >= VA) return 12'h000;
    return w ? BG : g ? GREY : BG;
  endfunction

  // Position is n cycles since reset release; registered outputs reflect position n-1.
  task automatic update_exp();
    int px, py;
    px = (n - 1) % HT;
    py = ((n - 1) / HT) % VT;
    e_x = n % HT;
    e_y = (n / HT) % VT;
    e_cnt = base + 32'(n / FT);
    if (fresh) begin
      e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_fc = 1'b0;
    end else begin
      e_rgb = ref_rgb(px, py, pg, pw);
      e_hs = !(px >= HA + HF && px < HA + HF + HS);
      e_vs = !(py >= VA + VF && py < VA + VF + VS);
      e_fc = py == VA;
    end
  endtask

  task automatic tick(input logic g, input logic w);
    inGrey = g;
    inWhite = w;
    @(posedge PixelClk);
    pg = g; pw = w; n++; fresh = 1'b0;
    @(negedge PixelClk);
    update_exp();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge PixelClk);
    @(negedge PixelClk);
    rst = 1'b0;
    n = 0; fresh = 1'b1; base = '0;
    update_exp();
  endtask

  task automatic test_reset();
    inGrey = 1'($urandom); inWhite = 1'($urandom);
    do_reset(3);
    tests++; if (vgaX !== 0) begin fails++; $display("FAIL reset_vgaX got %0d exp 0", vgaX); end
    tests++; if (vgaY !== 0) begin fails++; $display("FAIL reset_vgaY got %0d exp 0", vgaY); end
    tests++; if (rgb !== 12'h000) begin fails++; $display("FAIL reset_rgb got %h exp 000", rgb); end
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync got %b exp 1", hsync); end
    tests++; if (vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync got %b exp 1", vsync); end
    tests++; if (FrameClk !== 1'b0) begin fails++; $display("FAIL reset_frameclk got %b exp 0", FrameClk); end
    tests++; if (frameCount !== 0) begin fails++; $display("FAIL reset_framecount got %0d exp 0", frameCount); end
    tick(1'b0, 1'b0);
    tests++; if (vgaX !== 1 || rgb !== BG) begin fails++; $display("FAIL reset_first_step got x=%0d rgb=%h exp x=1 rgb=%h", vgaX, rgb, BG); end
  endtask

  task automatic test_frame_sync();
    int lows = 0, vlows = 0, falls = 0;
    logic last_hs = 1'b1;
    do_reset(1);
    for (int i = 0; i < FT; i++) begin
      tick(1'b0, 1'b0);
      tests++;
      if ({vgaX, vgaY, rgb, hsync, vsync} !== {32'(e_x), 32'(e_y), e_rgb, e_hs, e_vs}) begin
        fails++;
        $display("FAIL frame_cycle n=%0d got x=%0d y=%0d rgb=%h hs=%b vs=%b exp x=%0d y=%0d rgb=%h hs=%b vs=%b",
                 n, vgaX, vgaY, rgb, hsync, vsync, e_x, e_y, e_rgb, e_hs, e_vs);
      end
      if (last_hs && !hsync) begin
        falls++;
        tests++; if (n % HT != HA + HF + 1) begin fails++; $display("FAIL hsync_fall_offset got %0d exp %0d", n % HT, HA + HF + 1); end
      end
      lows += int'(!hsync);
      vlows += int'(!vsync);
      last_hs = hsync;
    end
    tests++; if (falls != VT) begin fails++; $display("FAIL hsync_falls got %0d exp %0d", falls, VT); end
    tests++; if (lows != HS * VT) begin fails++; $display("FAIL hsync_low_cycles got %0d exp %0d", lows, HS * VT); end
    tests++; if (vlows != VS * HT) begin fails++; $display("FAIL vsync_low_cycles got %0d exp %0d", vlows, VS * HT); end
    tests++; if (frameCount !== 1) begin fails++; $display("FAIL frame_count_one got %0d exp 1", frameCount); end
  endtask

  task automatic test_grey_pixel();
    localparam int GX = 5, GY = 7;
    int greys = 0;
    do_reset(1);
    for (int i = 0; i < FT; i++) begin
      tick(e_x == GX && e_y == GY, 1'b0);
      tests++; if (rgb !== e_rgb) begin fails++; $display("FAIL grey_rgb n=%0d got %h exp %h", n, rgb, e_rgb); end
      if (rgb === GREY) begin
        greys++;
        tests++;
        if ((n - 1) % HT != GX || ((n - 1) / HT) % VT != GY) begin
          fails++; $display("FAIL grey_position got n=%0d exp position (%0d,%0d)", n, GX, GY);
        end
      end
    end
    tests++; if (greys != 1) begin fails++; $display("FAIL grey_count got %0d exp 1", greys); end
  endtask

  task automatic test_all_white();
    do_reset(1);
    for (int i = 0; i < FT; i++) begin
      tick(1'b1, 1'b1);
      tests++; if (rgb !== e_rgb) begin fails++; $display("FAIL white_rgb n=%0d got %h exp %h", n, rgb, e_rgb); end
    end
  endtask

  task automatic test_frameclk();
    int edges = 0, last_edge = -1, high = 0;
    logic last_fc = 1'b0;
    do_reset(1);
    for (int i = 0; i < 3 * FT; i++) begin
      tick(1'($urandom), 1'($urandom));
      tests++; if (FrameClk !== e_fc) begin fails++; $display("FAIL frameclk_level n=%0d got %b exp %b", n, FrameClk, e_fc); end
      if (!last_fc && FrameClk) begin
        edges++;
        tests++; if (n % FT != VA * HT + 1) begin fails++; $display("FAIL frameclk_edge_pos got %0d exp %0d", n % FT, VA * HT + 1); end
        if (last_edge >= 0) begin
          tests++; if (n - last_edge != FT) begin fails++; $display("FAIL frameclk_spacing got %0d exp %0d", n - last_edge, FT); end
        end
        last_edge = n;
      end
      if (last_fc && !FrameClk) begin
        tests++; if (high != HT) begin fails++; $display("FAIL frameclk_high got %0d exp %0d", high, HT); end
        high = 0;
      end
      if (FrameClk) high++;
      last_fc = FrameClk;
    end
    tests++; if (edges != 3) begin fails++; $display("FAIL frameclk_edges got %0d exp 3", edges); end
    tests++; if (frameCount !== 3) begin fails++; $display("FAIL frameclk_count got %0d exp 3", frameCount); end
  endtask

  task automatic test_mid_reset();
    int edges = 0;
    logic last_fc = 1'b0;
    do_reset(1);
    while (n < FT + (VA + VF) * HT + HA + HF + 2) begin
      tick(1'($urandom), 1'($urandom));
      tests++;
      if ({rgb, hsync, vsync, FrameClk, frameCount} !== {e_rgb, e_hs, e_vs, e_fc, e_cnt}) begin
        fails++; $display("FAIL pre_reset n=%0d got rgb=%h hs=%b vs=%b fc=%b cnt=%0d exp rgb=%h hs=%b vs=%b fc=%b cnt=%0d",
                          n, rgb, hsync, vsync, FrameClk, frameCount, e_rgb, e_hs, e_vs, e_fc, e_cnt);
      end
    end
    tests++; if (hsync !== 1'b0 || vsync !== 1'b0) begin fails++; $display("FAIL pre_reset_syncs got hs=%b vs=%b exp 0 0", hsync, vsync); end
    do_reset(1);
    tests++;
    if ({vgaX, vgaY, hsync, vsync, frameCount, FrameClk} !== {32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0}) begin
      fails++; $display("FAIL mid_reset got x=%0d y=%0d hs=%b vs=%b cnt=%0d fc=%b exp 0 0 1 1 0 0",
                        vgaX, vgaY, hsync, vsync, frameCount, FrameClk);
    end
    for (int i = 0; i < FT; i++) begin
      tick(1'($urandom), 1'($urandom));
      if (!last_fc && FrameClk) edges++;
      last_fc = FrameClk;
    end
    tests++; if (edges != 1) begin fails++; $display("FAIL post_reset_edges got %0d exp 1", edges); end
    tests++; if (frameCount !== 1) begin fails++; $display("FAIL post_reset_count got %0d exp 1", frameCount); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    repeat (10) tick(1'b0, 1'b0);
    force dut.frameCount = 32'hFFFF_FFFF;
    tick(1'b0, 1'b0);
    release dut.frameCount;
    base = 32'hFFFF_FFFF;
    update_exp();
    tests++; if (frameCount !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_preload got %h exp ffffffff", frameCount); end
    while (n < FT) tick(1'($urandom), 1'($urandom));
    tests++; if (frameCount !== 32'd0 || e_cnt !== 32'd0) begin fails++; $display("FAIL wrap_zero got %h exp 00000000", frameCount); end
  endtask

  task automatic test_random();
    do_reset(1 + int'($urandom_range(0, 3)));
    for (int i = 0; i < FT + 37; i++) begin
      tick(1'($urandom), 1'($urandom));
      tests++;
      if ({vgaX, vgaY, rgb, hsync, vsync, FrameClk, frameCount} !==
          {32'(e_x), 32'(e_y), e_rgb, e_hs, e_vs, e_fc, e_cnt}) begin
        fails++; $display("FAIL random n=%0d got x=%0d y=%0d rgb=%h hs=%b vs=%b fc=%b cnt=%0d exp x=%0d y=%0d rgb=%h hs=%b vs=%b fc=%b cnt=%0d",
                          n, vgaX, vgaY, rgb, hsync, vsync, FrameClk, frameCount, e_x, e_y, e_rgb, e_hs, e_vs, e_fc, e_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_sync();
    test_grey_pixel();
    test_all_white();
    test_frameclk();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_scan_driver.md
VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, hsync pulse width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync pulse width, lines
- V_BP, 33, vertical back porch, lines
- GREY, 12'h555, RGB444 colour for foreground
- BG, 12'hFFF, RGB444 colour for background and white cutouts

REQ-002 SHALL have ports, one per line: name direction width meaning.
- PixelClk in 1 pixel clock; the only clock
- rst in 1 reset, synchronous, active-high
- inGrey in 1 OR of all delegate grey hits for the current vgaX/vgaY
- inWhite in 1 OR of all delegate white hits for the current vgaX/vgaY
- vgaX out 32 current horizontal scan position
- vgaY out 32 current vertical scan position
- FrameClk out 1 frame tick that steps the delegates
- hsync out 1 horizontal sync, active-low
- vsync out 1 vertical sync, active-low
- rgb out 12 pixel colour, {R[3:0],G[3:0],B[3:0]}
- frameCount out 32 completed-frame counter

Function
REQ-003 SHALL derive totals H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-004 SHALL keep hCount in 0..H_TOTAL-1 and increment it every PixelClk cycle.
- At H_TOTAL-1, hCount SHALL wrap to 0.
REQ-005 SHALL keep vCount in 0..V_TOTAL-1 and increment it only in a cycle where hCount wraps.
- At V_TOTAL-1, coincident with the hCount wrap, vCount SHALL wrap to 0.
REQ-006 SHALL drive vgaX = hCount and vgaY = vCount combinationally, zero-extended to 32 bits.
- Delegates evaluate inGrey/inWhite combinationally within the same cycle.
REQ-007 SHALL compute videoOn = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
REQ-008 SHALL register rgb one cycle after the vgaX/vgaY that produced it, with priority:
- !videoOn -> 12'h000
- else inWhite -> BG
- else inGrey -> GREY
- else BG
REQ-009 SHALL register hsync low iff hCount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
- hsync has the same 1-cycle latency as rgb.
REQ-010 SHALL register vsync low iff vCount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
- vsync has the same 1-cycle latency as rgb.
REQ-011 SHALL register FrameClk high iff vCount == V_ACTIVE.
- High for exactly H_TOTAL cycles per frame; rising edge one cycle after entering line 480.
- Delegates therefore update only during blanking.
REQ-012 SHALL increment frameCount by 1 in the cycle where both hCount and vCount wrap.
- frameCount wraps modulo 2^32 with no saturation.
REQ-013 SHALL treat inGrey and inWhite as don't-care outside videoOn; they SHALL NOT affect sync, counters or FrameClk.
REQ-014 SHALL produce exactly one FrameClk rising edge per frame, including the first frame after reset.

Reset
REQ-015 SHALL, while rst is sampled high on a PixelClk edge, load:
- hCount = 0, vCount = 0
- rgb = 12'h000
- hsync = 1, vsync = 1
- FrameClk = 0
- frameCount = 0
REQ-016 SHALL, in the first cycle after rst is released, present vgaX = 0 and vgaY = 0; the first valid rgb follows one cycle later.
REQ-017 SHALL, if rst is asserted mid-frame (including during FrameClk high or a sync pulse), abandon the frame immediately.
- rst SHALL NOT produce a frameCount increment or an extra FrameClk edge.

Verification
REQ-018 SHALL, from reset with inGrey = inWhite = 0, run one frame (420000 cycles) and check:
- hsync low for 96 cycles per line, falling edge 657 cycles after line start (registered)
- vsync low on lines 490..491
- frameCount = 1 at the end
REQ-019 SHALL drive inGrey = 1 only when vgaX == 100 && vgaY == 200 and check:
- rgb = 12'h555 exactly one cycle after that position is presented
- rgb = 12'hFFF at all other active pixels
REQ-020 SHALL hold inGrey = inWhite = 1 throughout a frame and check:
- all active pixels rgb = 12'hFFF
- all blanking pixels rgb = 12'h000
REQ-021 SHALL count FrameClk over 3 frames and check:
- exactly 3 rising edges, spaced 420000 cycles apart
- each edge one cycle after vgaY becomes 480
- each high period 800 cycles
REQ-022 SHALL assert rst for one cycle at vgaX = 700, vgaY = 490 and check:
- next cycle vgaX = 0, vgaY = 0, hsync = 1, vsync = 1, frameCount = 0, FrameClk = 0
REQ-023 SHALL force frameCount to 32'hFFFFFFFF and complete one frame, then check frameCount = 0.
